// File: rtl/wb_periph_ctrl_if.sv
// Upstream Wishbone slave port of the peripheral controller (Caravel wbs_* bundle).
interface wb_periph_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_periph_ctrl.sv
// Single-outstanding Wishbone page decoder with bus watchdog, decode-error response
// and a local fault/config register page at page 0.
module wb_periph_ctrl #(
    parameter int          NSLV     = 5,
    parameter logic [15:0] BASE_HI  = 16'h3000,
    parameter logic [15:0] TOUT_RST = 16'd255,
    parameter logic [31:0] ERR_DATA = 32'hDEADC0DE
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    wb_periph_ctrl_if.slave      wbs,
    output logic                 s_cyc_o,
    output logic [NSLV-1:0]      s_stb_o,
    output logic                 s_we_o,
    output logic [3:0]           s_sel_o,
    output logic [11:0]          s_adr_o,
    output logic [31:0]          s_dat_o,
    input  logic [NSLV-1:0]      s_ack_i,
    input  logic [32*NSLV-1:0]   s_dat_i,
    output logic                 irq_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q;
    logic [NSLV-1:0]   stb_sel_q;
    logic [15:0]       timer_q;
    logic [15:0]       tout_q;
    logic [1:0]        irqen_q;
    logic              tout_st_q, decerr_q;
    logic [3:0]        fault_idx_q;

    logic              req, base_ok, dec_hit, dec_local;
    logic [3:0]        dec_idx;
    logic [NSLV-1:0]   dec_onehot;
    logic              ack_hit, tout_hit;
    logic [31:0]       slv_rdata, loc_rdata;

    assign req        = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign dec_idx    = wbs.wbs_adr_i[15:12];
    assign base_ok    = (wbs.wbs_adr_i[31:16] == BASE_HI);
    assign dec_hit    = base_ok && (dec_idx != 4'd0) && (dec_idx <= 4'(NSLV));
    assign dec_local  = base_ok && (dec_idx == 4'd0);
    assign dec_onehot = NSLV'(1) << (dec_idx - 4'd1);

    // Only the latched page's ack counts; stray acks from other peripherals are masked.
    assign ack_hit  = |(s_ack_i & stb_sel_q);
    assign tout_hit = (tout_q != 16'd0) && ((timer_q + 16'd1) == tout_q);

    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (stb_sel_q[i]) slv_rdata = slv_rdata | s_dat_i[i*32 +: 32];
        end
    end

    always_comb begin
        loc_rdata = '0;
        case (wbs.wbs_adr_i[7:0])
            8'h00:   loc_rdata = {24'd0, fault_idx_q, 2'b00, decerr_q, tout_st_q};
            8'h04:   loc_rdata = {16'd0, tout_q};
            8'h08:   loc_rdata = {30'd0, irqen_q};
            default: loc_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = dec_hit ? ACCESS : RESP;
            ACCESS: begin
                if (!wbs.wbs_cyc_i)          state_d = IDLE;
                else if (ack_hit || tout_hit) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o = (state_q == ACCESS);
        s_stb_o = (state_q == ACCESS) ? stb_sel_q : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
            idx_q         <= '0;
            stb_sel_q     <= '0;
            timer_q       <= '0;
            s_we_o        <= 1'b0;
            s_sel_o       <= '0;
            s_adr_o       <= '0;
            s_dat_o       <= '0;
            tout_q        <= TOUT_RST;
            irqen_q       <= '0;
            tout_st_q     <= 1'b0;
            decerr_q      <= 1'b0;
            fault_idx_q   <= '0;
            irq_o         <= 1'b0;
        end else begin
            wbs.wbs_ack_o <= (state_d == RESP);
            case (state_q)
                IDLE: if (req) begin
                    if (dec_hit) begin
                        idx_q     <= dec_idx;
                        stb_sel_q <= dec_onehot;
                        s_we_o    <= wbs.wbs_we_i;
                        s_sel_o   <= wbs.wbs_sel_i;
                        s_adr_o   <= wbs.wbs_adr_i[11:0];
                        s_dat_o   <= wbs.wbs_dat_i;
                        timer_q   <= '0;
                    end else if (dec_local) begin
                        // Local writes return the register contents from before the write.
                        wbs.wbs_dat_o <= loc_rdata;
                        if (wbs.wbs_we_i) begin
                            case (wbs.wbs_adr_i[7:0])
                                8'h00: if (wbs.wbs_sel_i[0]) begin
                                    if (wbs.wbs_dat_i[0]) tout_st_q <= 1'b0;
                                    if (wbs.wbs_dat_i[1]) decerr_q  <= 1'b0;
                                end
                                8'h04: begin
                                    if (wbs.wbs_sel_i[0]) tout_q[7:0]  <= wbs.wbs_dat_i[7:0];
                                    if (wbs.wbs_sel_i[1]) tout_q[15:8] <= wbs.wbs_dat_i[15:8];
                                end
                                8'h08: if (wbs.wbs_sel_i[0]) irqen_q <= wbs.wbs_dat_i[1:0];
                                default: ;
                            endcase
                        end
                    end else begin
                        wbs.wbs_dat_o <= ERR_DATA;
                        decerr_q      <= 1'b1;
                        fault_idx_q   <= 4'hF;
                    end
                end
                ACCESS: begin
                    timer_q <= timer_q + 16'd1;
                    if (wbs.wbs_cyc_i) begin
                        if (ack_hit) begin
                            wbs.wbs_dat_o <= slv_rdata;
                        end else if (tout_hit) begin
                            wbs.wbs_dat_o <= ERR_DATA;
                            tout_st_q     <= 1'b1;
                            fault_idx_q   <= idx_q;
                        end
                    end
                end
                default: ;
            endcase
            irq_o <= |({decerr_q, tout_st_q} & irqen_q);
        end
    end

endmodule

// File: tb/tb_wb_periph_ctrl.sv
// Bench for wb_periph_ctrl: vector table through a scoreboarded bus master, plus
// hand-written abort, foreign-ack, watchdog-disabled and mid-access reset sequences.
module tb_wb_periph_ctrl;
    localparam int NSLV = 5;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        chk_en;
        logic [31:0] exp_dat;
        int          exp_lat;
        logic [4:0]  exp_stb;
        logic [11:0] exp_sadr;
        logic        exp_irq;
    } vec_t;

    typedef struct {
        int          id;
        logic        chk;
        logic [31:0] dat;
    } sb_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             s_cyc_o, s_we_o, irq_o;
    logic [NSLV-1:0]  s_stb_o, s_ack_i, force_ack;
    logic [3:0]       s_sel_o;
    logic [11:0]      s_adr_o;
    logic [31:0]      s_dat_o;
    logic [32*NSLV-1:0] s_dat_i;

    int               lat_cfg[NSLV];
    logic [31:0]      sdat[NSLV];
    int               cnt[NSLV];
    int               n_cmp = 0;
    int               n_err = 0;
    sb_t              sb_q[$];
    vec_t             vecs[$];

    wb_periph_ctrl_if wbs_if();

    wb_periph_ctrl #(
        .NSLV(NSLV), .BASE_HI(16'h3000), .TOUT_RST(16'd255), .ERR_DATA(32'hDEADC0DE)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(wbs_if),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Peripheral models: ack after lat_cfg strobe cycles (negative = never), plus a raw override.
    always @(posedge clk) begin
        for (int i = 0; i < NSLV; i++) cnt[i] <= s_stb_o[i] ? cnt[i] + 1 : 0;
    end

    always_comb begin
        s_ack_i = '0;
        s_dat_i = '0;
        for (int i = 0; i < NSLV; i++) begin
            s_ack_i[i] = force_ack[i] | (s_stb_o[i] && lat_cfg[i] >= 0 && cnt[i] == lat_cfg[i]);
            s_dat_i[i*32 +: 32] = sdat[i];
        end
    end

    function automatic void chk(string name, int id, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got 0x%08h, want 0x%08h", name, id, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic [31:0] adr, logic we, logic [3:0] sel, logic [31:0] wdat,
                                logic chk_en, logic [31:0] exp_dat, int exp_lat,
                                logic [4:0] exp_stb, logic [11:0] exp_sadr, logic exp_irq);
        vec_t v;
        v.adr = adr; v.we = we; v.sel = sel; v.wdat = wdat; v.chk_en = chk_en;
        v.exp_dat = exp_dat; v.exp_lat = exp_lat; v.exp_stb = exp_stb;
        v.exp_sadr = exp_sadr; v.exp_irq = exp_irq;
        return v;
    endfunction

    // Every upstream ack consumes one scoreboard entry; an ack with nothing pending is an error.
    always @(negedge clk) begin
        if (wbs_if.wbs_ack_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: got ack with data 0x%08h, want no ack", wbs_if.wbs_dat_o);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.chk) chk("rdata", e.id, wbs_if.wbs_dat_o, e.dat);
            end
        end
    end

    task automatic drive(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdat);
        wbs_if.wbs_adr_i = adr;
        wbs_if.wbs_we_i  = we;
        wbs_if.wbs_sel_i = sel;
        wbs_if.wbs_dat_i = wdat;
        wbs_if.wbs_cyc_i = 1'b1;
        wbs_if.wbs_stb_i = 1'b1;
    endtask

    task automatic idle_bus();
        wbs_if.wbs_cyc_i = 1'b0;
        wbs_if.wbs_stb_i = 1'b0;
        wbs_if.wbs_we_i  = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the ack cycle with the bus idle.
    task automatic xfer(input int id, input vec_t v);
        int   lat;
        logic stb_seen, stb_bad, adr_bad;
        sb_t  e;
        e.id = id; e.chk = v.chk_en; e.dat = v.exp_dat;
        sb_q.push_back(e);
        drive(v.adr, v.we, v.sel, v.wdat);
        lat = 0; stb_seen = 1'b0; stb_bad = 1'b0; adr_bad = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (s_stb_o != '0) begin
                stb_seen = 1'b1;
                if (s_stb_o != v.exp_stb)  stb_bad = 1'b1;
                if (s_adr_o != v.exp_sadr) adr_bad = 1'b1;
            end
            if (wbs_if.wbs_ack_o) begin
                lat = n;
                break;
            end
        end
        chk("latency", id, 32'(lat), 32'(v.exp_lat));
        chk("strobe", id, 32'({stb_bad, stb_seen}), 32'({1'b0, v.exp_stb != 5'd0}));
        if (v.exp_stb != 5'd0) chk("s_adr", id, 32'({adr_bad, s_adr_o}), 32'({1'b0, v.exp_sadr}));
        @(posedge clk);
        #1;
        idle_bus();
        chk("irq", id, 32'(irq_o), 32'(v.exp_irq));
    endtask

    task automatic chk_reset_outputs(input int id);
        chk("rst_ctl", id, 32'({wbs_if.wbs_ack_o, s_cyc_o, s_stb_o, s_we_o, irq_o}), 32'd0);
        chk("rst_wdat", id, wbs_if.wbs_dat_o, 32'd0);
        chk("rst_sdat", id, s_dat_o, 32'd0);
        chk("rst_seladr", id, 32'({s_sel_o, s_adr_o}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle_bus();
        wbs_if.wbs_adr_i = '0;
        wbs_if.wbs_sel_i = '0;
        wbs_if.wbs_dat_i = '0;
        force_ack = '0;
        sdat[0] = 32'h1111_0001; sdat[1] = 32'h1234_5678; sdat[2] = 32'h3333_0003;
        sdat[3] = 32'h4444_0004; sdat[4] = 32'h5555_0005;
        lat_cfg[0] = 0; lat_cfg[1] = 0; lat_cfg[2] = -1; lat_cfg[3] = 2; lat_cfg[4] = 1;

        //           adr           we    sel      wdat          chk   exp_dat        lat stb       sadr    irq
        vecs.push_back(mk(32'h3000_2010, 1'b0, 4'hF, 32'h0,        1'b1, 32'h1234_5678, 2, 5'b00010, 12'h010, 1'b0));
        vecs.push_back(mk(32'h3000_0004, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_00FF, 1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0004, 1'b1, 4'hF, 32'h4,        1'b0, 32'h0,         1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0008, 1'b1, 4'hF, 32'h1,        1'b0, 32'h0,         1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0004, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_0004, 1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0008, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_0001, 1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_3000, 1'b0, 4'hF, 32'h0,        1'b1, 32'hDEAD_C0DE, 5, 5'b00100, 12'h000, 1'b1));
        vecs.push_back(mk(32'h3000_0000, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_0031, 1, 5'b00000, 12'h000, 1'b1));
        vecs.push_back(mk(32'h3000_0000, 1'b1, 4'h1, 32'h1,        1'b0, 32'h0,         1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0000, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_0030, 1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_4ABC, 1'b1, 4'hF, 32'hCAFEF00D, 1'b1, 32'h4444_0004, 4, 5'b01000, 12'hABC, 1'b0));
        vecs.push_back(mk(32'h3000_5008, 1'b0, 4'hF, 32'h0,        1'b1, 32'h5555_0005, 3, 5'b10000, 12'h008, 1'b0));
        vecs.push_back(mk(32'h3000_1FFC, 1'b0, 4'hF, 32'h0,        1'b1, 32'h1111_0001, 2, 5'b00001, 12'hFFC, 1'b0));
        vecs.push_back(mk(32'h3000_7000, 1'b0, 4'hF, 32'h0,        1'b1, 32'hDEAD_C0DE, 1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3100_1000, 1'b1, 4'hF, 32'h12345678, 1'b1, 32'hDEAD_C0DE, 1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0000, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_00F2, 1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0008, 1'b1, 4'hF, 32'h3,        1'b0, 32'h0,         1, 5'b00000, 12'h000, 1'b1));
        vecs.push_back(mk(32'h3000_0000, 1'b1, 4'hE, 32'h3,        1'b0, 32'h0,         1, 5'b00000, 12'h000, 1'b1));
        vecs.push_back(mk(32'h3000_0000, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_00F2, 1, 5'b00000, 12'h000, 1'b1));
        vecs.push_back(mk(32'h3000_0000, 1'b1, 4'h1, 32'h2,        1'b0, 32'h0,         1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0000, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_00F0, 1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_000C, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_0000, 1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0004, 1'b1, 4'h2, 32'h1200,     1'b0, 32'h0,         1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0004, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000_1204, 1, 5'b00000, 12'h000, 1'b0));
        vecs.push_back(mk(32'h3000_0004, 1'b1, 4'hF, 32'h4,        1'b0, 32'h0,         1, 5'b00000, 12'h000, 1'b0));

        // Reset state, asserted asynchronously between clock edges.
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs(0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_reset_outputs(1);

        for (int i = 0; i < vecs.size(); i++) xfer(i, vecs[i]);

        // Page 2 access while peripheral 1 drives a stray ack the whole time.
        lat_cfg[1] = 2;
        force_ack[0] = 1'b1;
        xfer(100, mk(32'h3000_2020, 1'b0, 4'hF, 32'h0, 1'b1, 32'h1234_5678, 4, 5'b00010, 12'h020, 1'b0));
        force_ack[0] = 1'b0;
        lat_cfg[1] = 0;

        // Master abandons a page 1 access.
        lat_cfg[0] = -1;
        drive(32'h3000_1000, 1'b0, 4'hF, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_active", 101, 32'({s_cyc_o, s_stb_o}), 32'({1'b1, 5'b00001}));
        @(posedge clk);
        #1 idle_bus();
        @(posedge clk);
        @(negedge clk);
        chk("abort_drop", 102, 32'({s_cyc_o, s_stb_o}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        lat_cfg[0] = 0;
        xfer(103, mk(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_00F0, 1, 5'b00000, 12'h000, 1'b0));
        xfer(104, mk(32'h3000_4100, 1'b0, 4'hF, 32'h0, 1'b1, 32'h4444_0004, 4, 5'b01000, 12'h100, 1'b0));

        // Watchdog disabled: a silent peripheral holds ACCESS until the master gives up.
        xfer(105, mk(32'h3000_0004, 1'b1, 4'hF, 32'h0, 1'b0, 32'h0, 1, 5'b00000, 12'h000, 1'b0));
        drive(32'h3000_3000, 1'b0, 4'hF, 32'h0);
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("tout0_hold", 106, 32'({s_cyc_o, s_stb_o}), 32'({1'b1, 5'b00100}));
        @(posedge clk);
        #1 idle_bus();
        @(posedge clk);
        @(negedge clk);
        chk("tout0_drop", 107, 32'({s_cyc_o, s_stb_o}), 32'd0);
        @(posedge clk);
        #1;
        xfer(108, mk(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_00F0, 1, 5'b00000, 12'h000, 1'b0));

        // Reset in the middle of an access, then a stale ack from the abandoned peripheral.
        drive(32'h3000_3ABC, 1'b1, 4'hA, 32'hA5A5_5A5A);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_access", 109, 32'({s_cyc_o, s_stb_o, s_adr_o}), 32'({1'b1, 5'b00100, 12'hABC}));
        rst_n = 1'b0;
        #1 chk_reset_outputs(110);
        idle_bus();
        force_ack[2] = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_idle", 111, 32'({s_cyc_o, s_stb_o, wbs_if.wbs_ack_o}), 32'd0);
        force_ack = '0;
        @(posedge clk);
        #1;
        xfer(112, mk(32'h3000_0004, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_00FF, 1, 5'b00000, 12'h000, 1'b0));
        xfer(113, mk(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_0000, 1, 5'b00000, 12'h000, 1'b0));
        xfer(114, mk(32'h3000_0008, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_0000, 1, 5'b00000, 12'h000, 1'b0));

        repeat (2) @(posedge clk);
        chk("sb_drained", 115, 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_periph_ctrl.md
# wb_periph_ctrl

Wishbone bus controller that sits between the Caravel management SoC slave port (the user project's `wbs_*` interface) and the user-area peripherals (PWM/timer, I2C, RTC, PID and similar). It decodes each request to one peripheral and runs it as a single-outstanding transaction. A bus watchdog terminates hung accesses, and requests to unmapped pages get a deterministic error response. The block also exposes a small local register page holding fault status, the watchdog limit and interrupt enables.

## Interface
Parameters:
- `NSLV`, 5: number of downstream peripherals (1..14), mapped to pages 1..NSLV.
- `BASE_HI`, 16'h3000: required value of `wbs_adr_i[31:16]`.
- `TOUT_RST`, 16'd255: reset value of the watchdog limit register.
- `ERR_DATA`, 32'hDEADC0DE: read data returned on decode error or timeout.

Ports:
- `wb_clk_i`  in  1  clock; the block's only clock.
- `wb_rst_ni`  in  1  reset, asynchronous assert, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1  upstream Wishbone controls.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`, `wbs_dat_i`  in  32  upstream address and write data.
- `wbs_ack_o`  out  1  upstream acknowledge, registered.
- `wbs_dat_o`  out  32  upstream read data, registered.
- `s_cyc_o`  out  1  downstream cycle.
- `s_stb_o`  out  NSLV  one-hot downstream strobe; bit i-1 selects page i.
- `s_we_o`  out  1  latched write enable.
- `s_sel_o`  out  4  latched byte selects.
- `s_adr_o`  out  12  latched `wbs_adr_i[11:0]`.
- `s_dat_o`  out  32  latched write data.
- `s_ack_i`  in  NSLV  per-peripheral acknowledge.
- `s_dat_i`  in  32*NSLV  per-peripheral read data; slice i-1 belongs to page i.
- `irq_o`  out  1  fault interrupt, level.

## Operation
- Page decode, evaluated in IDLE:
  - `idx = wbs_adr_i[15:12]`.
  - Hit: `wbs_adr_i[31:16]==BASE_HI` and `1<=idx<=NSLV`.
  - Local: BASE matches and `idx==0`.
  - Anything else is a decode error.
- FSM state IDLE:
  - Acts on `wbs_cyc_i & wbs_stb_i`.
  - Hit: latch idx/we/sel/adr/dat, clear the timer, go to ACCESS.
  - Local or decode error: perform the local access or set DECERR, then go to RESP.
- FSM state ACCESS:
  - `s_cyc_o=1`; `s_stb_o[idx-1]=1`; all other strobes 0.
  - On `s_ack_i[idx-1]`: capture `s_dat_i` slice, drop the strobe, go to RESP.
  - Timer increments each cycle. When `TOUT!=0` and the timer reaches `TOUT` without an ack: drop the strobe, load `ERR_DATA`, set TOUT_ST, record idx, go to RESP.
  - If `wbs_cyc_i` falls: drop `s_cyc_o`/strobe and return to IDLE with no ack (abort). No status change.
  - Acks on non-selected `s_ack_i` bits are ignored.
- FSM state RESP: `wbs_ack_o=1` for exactly one cycle with `wbs_dat_o` valid, then go to IDLE.
- Write data is returned on writes too: writes return the captured slave data; decode-error writes return `ERR_DATA`.
- Local registers, addressed by `wbs_adr_i[7:0]`:
  - 0x00 STATUS:
    - [0] TOUT_ST, [1] DECERR_ST; both write-1-to-clear.
    - [7:4] last faulting idx; 0xF for a decode error.
    - A W1C bit and a new fault in the same cycle: the fault wins.
  - 0x04 TOUT [15:0], RW. Value 0 disables the watchdog.
  - 0x08 IRQEN [1:0], RW.
  - Other offsets read 0; writes to them are ignored; they are still acked.
  - Writes honour `wbs_sel_i` per byte.
- `irq_o = |(STATUS[1:0] & IRQEN[1:0])`, registered.
- Reset values:
  - State IDLE.
  - `wbs_ack_o`, `s_cyc_o`, `s_stb_o`, `s_we_o`, `irq_o` all 0.
  - `wbs_dat_o`, `s_adr_o`, `s_dat_o`, `s_sel_o` all 0.
  - STATUS=0, TOUT=`TOUT_RST`, IRQEN=0.
- Reset asserted mid-ACCESS: all outputs go to their reset values immediately. No ack is ever issued for that request.

## Timing
- Request first sampled at edge T (`wbs_stb_i` high in cycle T-1 → decode registered):
  - `s_stb_o` is high from cycle T.
  - Slave ack sampled at edge T+k gives `wbs_ack_o` high in cycle T+k, for one cycle.
  - Minimum peripheral latency is 2 cycles from upstream strobe to upstream ack.
- Local register or decode error: `wbs_ack_o` high in the cycle after the request is sampled (1 cycle).
- Timeout: the strobe drops after `TOUT` ACCESS cycles; `wbs_ack_o` follows on the next cycle.
- The master holds `stb` until it sees the ack. The cycle after RESP is IDLE and may accept a new request; back-to-back requests cost 0 extra idle cycles.
- STATUS updates and the resulting `irq_o` appear 1 cycle after the RESP cycle.

## Test plan
- Read from page 2 (`0x3000_2010`), slave 2 acks on its 1st strobe cycle with 0x1234_5678 → only `s_stb_o[1]` is asserted, `s_adr_o`=0x010, `wbs_dat_o`=0x1234_5678, `wbs_ack_o` is high for one cycle 2 cycles after the request.
- Write TOUT=4, IRQEN=1, then access page 3 with no slave ack → strobe drops after 4 cycles, ack with 0xDEADC0DE, STATUS=0x31, `irq_o`=1. Write STATUS=0x1 → STATUS=0x30, `irq_o`=0.
- Access `0x3000_7000` with NSLV=5, and separately `0x3100_1000` → 1-cycle ack, data 0xDEADC0DE, DECERR_ST=1, STATUS[7:4]=0xF, no `s_stb_o` activity.
- Drop `wbs_cyc_i` during ACCESS on page 1 → `s_cyc_o`/`s_stb_o` fall next cycle, no `wbs_ack_o`, STATUS unchanged. A following request on page 4 completes normally.
- Assert `wb_rst_ni`=0 mid-ACCESS → all outputs go to 0 asynchronously, TOUT reads back 255 after release, and the stale slave ack arriving after reset causes no upstream ack.
- Slave 1 asserts ack while page 2 is being accessed → ignored. TOUT=0 with a silent slave keeps ACCESS indefinitely until `wbs_cyc_i` drops.
